// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared constants for the Sobel row scheduler and PE chain.
//               Holds state encodings, default geometry, data widths and a
//               small counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  // Data widths used by the PE chain
  localparam int PIX_W  = 8;
  localparam int PSUM_W = 16;

  // Default geometry
  localparam int SOBEL_TAPS     = 3;
  localparam int SOBEL_PIPE_LAT = SOBEL_TAPS;
  localparam int SOBEL_IMG_W    = 640;
  localparam int SOBEL_IMG_H    = 480;

  // Scheduler state encoding
  localparam int ST_W = 3;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_ROW = 3'd1;
  localparam logic [2:0] ST_STREAM   = 3'd2;
  localparam logic [2:0] ST_FLUSH    = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Counter width for a range of n values; never returns 0 so that
  // degenerate geometries (e.g. a single row) still get a real register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sobel_tag_pipe
// Description : DEPTH-stage delay line for the {valid,row,col} result tag.
//               The tail is the tag aligned with the PE chain output.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid/row/col  : tag entering alongside the broadcast pixel
//   out_valid/row/col : tag leaving the last stage
//   pending        : a valid tag sits in any stage other than the tail
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_tag_pipe
  import sobel_pkg::*;
#(
  parameter int DEPTH = SOBEL_PIPE_LAT,
  parameter int RW    = 9,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          pending
);

  logic [DEPTH-1:0] r_valid;
  logic [RW-1:0]    r_row [DEPTH];
  logic [CW-1:0]    r_col [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_row[0]   <= in_row;
      r_col[0]   <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_row[i]   <= r_row[i-1];
        r_col[i]   <= r_col[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_row   = r_row[DEPTH-1];
  assign out_col   = r_col[DEPTH-1];

  // The tail is excluded: it empties on the next edge regardless.
  generate
    if (DEPTH > 1) begin : g_pending
      assign pending = |r_valid[DEPTH-2:0];
    end else begin : g_no_pending
      assign pending = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sobel_row_sched.sv
`default_nettype none
// ============================================================================
// Module      : sobel_row_sched
// Description : Row scheduler for the Sobel PE chain. Streams each row from
//               the line buffer to the PEs without gaps, inserts PIPE_LAT
//               zero-flush cycles after every row and tags chain outputs
//               with valid/row/centre-column.
//   start/busy/done        : frame control
//   row_avail, s_valid/s_ready/s_pixel : upstream row-buffer stream
//   pe_x, pe_flush         : registered broadcast pixel to the PEs
//   res_valid/res_row/res_col : tag aligned with the chain output
//   err_underrun           : sticky, upstream starved during a row
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_row_sched
  import sobel_pkg::*;
#(
  parameter  int IMG_W    = SOBEL_IMG_W,
  parameter  int IMG_H    = SOBEL_IMG_H,
  parameter  int TAPS     = SOBEL_TAPS,
  parameter  int PIPE_LAT = SOBEL_PIPE_LAT,
  localparam int CW       = cnt_w(IMG_W),
  localparam int RW       = cnt_w(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             row_avail,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic [PIX_W-1:0] pe_x,
  output logic             pe_flush,
  output logic             res_valid,
  output logic [RW-1:0]    res_row,
  output logic [CW-1:0]    res_col,
  output logic             err_underrun
);

  localparam int FW = cnt_w(PIPE_LAT);

  localparam logic [CW-1:0] c_col_last   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] c_col_first  = CW'(TAPS - 1);
  localparam logic [CW-1:0] c_half       = CW'((TAPS - 1) / 2);
  localparam logic [RW-1:0] c_row_last   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] c_flush_last = FW'(PIPE_LAT - 1);

  logic [ST_W-1:0]  r_state;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [FW-1:0]    r_fcnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [PIX_W-1:0] r_pe_x;
  logic             r_pe_flush;
  // Tag registered in the same edge as pe_x, so it travels with the pixel.
  logic             r_x_valid;
  logic [RW-1:0]    r_x_row;
  logic [CW-1:0]    r_x_col;
  logic             w_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_fcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pe_x     <= '0;
      r_pe_flush <= 1'b0;
      r_x_valid  <= 1'b0;
      r_x_row    <= '0;
      r_x_col    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_pe_x     <= '0;
      r_pe_flush <= 1'b0;
      r_x_valid  <= 1'b0;
      r_x_row    <= '0;
      r_x_col    <= '0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_WAIT_ROW;
            r_row   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT_ROW: begin
          if (row_avail) begin
            r_state <= ST_STREAM;
            r_col   <= '0;
          end
        end
        ST_STREAM: begin
          // The PEs cannot stall: a missing pixel becomes a zero and the
          // column still advances.
          r_pe_x <= s_valid ? s_pixel : '0;
          if (!s_valid) begin
            r_err <= 1'b1;
          end
          if (r_col >= c_col_first) begin
            r_x_valid <= 1'b1;
            r_x_row   <= r_row;
            r_x_col   <= r_col - c_half;
          end
          if (r_col == c_col_last) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= '0;
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        ST_FLUSH: begin
          r_pe_flush <= 1'b1;
          if (r_fcnt == c_flush_last) begin
            if (r_row == c_row_last) begin
              r_state <= ST_DRAIN;
            end else begin
              r_row   <= r_row + RW'(1);
              r_state <= ST_WAIT_ROW;
            end
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end
        ST_DRAIN: begin
          // Leave once only the tail can still hold the final result, so
          // done lands on the cycle right after it.
          if (!r_x_valid && !w_pending) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  sobel_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .RW    (RW),
    .CW    (CW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (r_x_valid),
    .in_row    (r_x_row),
    .in_col    (r_x_col),
    .out_valid (res_valid),
    .out_row   (res_row),
    .out_col   (res_col),
    .pending   (w_pending)
  );

  assign s_ready      = (r_state == ST_STREAM);
  assign busy         = r_busy;
  assign done         = r_done;
  assign pe_x         = r_pe_x;
  assign pe_flush     = r_pe_flush;
  assign err_underrun = r_err;

endmodule
`default_nettype wire
